wb_fetch_arbiter: RTL

//  Two-master, read-only Wishbone arbiter that shares one memory slave port.

---
 rtl/wb_fetch_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_fetch_arbiter.sv
// Two-master read-only Wishbone arbiter: round-robin, owner locked while it holds CYC.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module wb_fetch_arbiter #(
  parameter int AW      = 15,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          sys_clk_i,
  input  logic          sys_res_i,
  input  logic [AW:1]   m0_adr_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  input  logic [AW:1]   m1_adr_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic [AW:1]   s_adr_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o,
  output logic          timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t     state, state_nxt;
  logic       last;
  logic [1:0] mask, req;
  logic       wd_fire;

  assign req = {m1_cyc_i & ~mask[1], m0_cyc_i & ~mask[0]};

  // last = master that most recently released the bus; a tie goes to the other one
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req == 2'b11)  state_nxt = last ? OWN0 : OWN1;
        else if (req[0])   state_nxt = OWN0;
        else if (req[1])   state_nxt = OWN1;
      end
      OWN0: if (!m0_cyc_i || wd_fire) state_nxt = req[1] ? OWN1 : IDLE;
      OWN1: if (!m1_cyc_i || wd_fire) state_nxt = req[0] ? OWN0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_res_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == OWN0 && state_nxt != OWN0) last <= 1'b0;
      if (state == OWN1 && state_nxt != OWN1) last <= 1'b1;
    end
  end

  always_comb begin
    s_adr_o = m0_adr_i;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    unique case (state)
      OWN0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
      end
      OWN1: begin
        s_adr_o = m1_adr_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
      end
      default: ;
    endcase
  end

  assign gnt_o    = {state == OWN1, state == OWN0};
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & (state == OWN0);
  assign m1_ack_o = s_ack_i & (state == OWN1);

`ifdef ARB_WATCHDOG_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] wd_cnt;
  logic          stall;
  logic [1:0]    cyc;

  assign cyc     = {m1_cyc_i, m0_cyc_i};
  assign stall   = s_stb_o & ~s_ack_i;
  assign wd_fire = stall & (wd_cnt == CW'(TIMEOUT));
  assign timeout_o = wd_fire;

  // a timed-out master stays locked out until it drops CYC
  always_ff @(posedge sys_clk_i) begin
    if (sys_res_i) begin
      wd_cnt <= '0;
      mask   <= '0;
    end else begin
      if (s_ack_i || state_nxt != state) wd_cnt <= '0;
      else if (stall)                    wd_cnt <= wd_cnt + CW'(1);
      for (int i = 0; i < 2; i++) begin
        if (wd_fire && gnt_o[i]) mask[i] <= 1'b1;
        else if (!cyc[i])        mask[i] <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign mask      = '0;
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule
